// File: rtl/encrypt.sv
// LWE public-key encryption stage feeding decrypt.
// Sums LFSR-selected public-key rows and adds the scaled plaintext.
module encrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int DIMENSION          = 1,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int BIG_N              = 30,
  localparam int AW = (BIG_N > 1) ? $clog2(BIG_N) : 1,
  localparam int CW = CIPHERTEXT_WIDTH,
  localparam int W  = (DIMENSION + 1) * CIPHERTEXT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PLAINTEXT_WIDTH-1:0] plaintext,
  input  logic                       seed_valid,
  input  logic [15:0]                seed,
  input  logic                       sel_all,
  output logic                       pk_re,
  output logic [AW-1:0]              pk_addr,
  input  logic [W-1:0]               pk_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               ciphertext
);

  // m*DELTA is a left shift since both moduli are powers of two
  localparam int DSH =
    $clog2(CIPHERTEXT_MODULUS) - $clog2(PLAINTEXT_MODULUS);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [AW-1:0] LAST = AW'(BIG_N - 1);

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, DONE
  } state_t;

  state_t      state;
  logic [W-1:0] acc;
  logic [W-1:0] acc_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        row_valid;
  logic        sel;

  // Per-row accumulate and LFSR step for the row currently on pk_row
  always_comb begin
    acc_next  = acc;
    sel       = sel_all | lfsr[0];
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    for (int i = 0; i <= DIMENSION; i++) begin
      acc_next[i*CW +: CW] = acc[i*CW +: CW]
        + (sel ? pk_row[i*CW +: CW] : {CW{1'b0}});
    end
  end

  // Control FSM, row fetch, accumulator and LFSR with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      pk_re      <= 1'b0;
      pk_addr    <= '0;
      ciphertext <= '0;
      acc        <= '0;
      lfsr       <= LFSR_INIT;
      row_valid  <= 1'b0;
    end else begin
      row_valid <= pk_re;
      unique case (state)
        IDLE: begin
          if (seed_valid) begin
            lfsr <= (seed == 16'd0) ? LFSR_INIT : seed;
          end
          if (in_valid) begin
            acc      <= W'(plaintext) << DSH;
            pk_re    <= 1'b1;
            pk_addr  <= '0;
            in_ready <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (row_valid) begin
            acc  <= acc_next;
            lfsr <= lfsr_next;
          end
          if (pk_addr == LAST) begin
            pk_re <= 1'b0;
            state <= DRAIN;
          end else begin
            pk_addr <= pk_addr + AW'(1);
          end
        end
        DRAIN: begin
          acc        <= acc_next;
          lfsr       <= lfsr_next;
          ciphertext <= acc_next;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt.sv
// Testbench for encrypt: vector table plus scoreboard,
// with backpressure, reset-abort and LFSR-selection sequences.
module tb_encrypt;
  localparam int N  = 30;
  localparam int CW = 10;
  localparam int W  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    plaintext;
  logic          seed_valid;
  logic [15:0]   seed;
  logic          sel_all;
  logic          pk_re;
  logic [4:0]    pk_addr;
  logic [W-1:0]  pk_row = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ciphertext;

  encrypt dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext),
    .seed_valid(seed_valid), .seed(seed),
    .sel_all(sel_all),
    .pk_re(pk_re), .pk_addr(pk_addr), .pk_row(pk_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [N];

  // 1-cycle sync-read public-key RAM
  always @(posedge clk) if (pk_re) pk_row <= mem[pk_addr];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] sb_e;

  typedef struct {
    logic [9:0] r0;
    logic [9:0] r1;
    logic [5:0] m;
    logic [9:0] e0;
    logic [9:0] e1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare each transferred ciphertext to the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none",
                 ciphertext);
      end else begin
        sb_e = sb.pop_front();
        chk("ct0", 32'(ciphertext[9:0]), 32'(sb_e[9:0]));
        chk("ct1", 32'(ciphertext[19:10]), 32'(sb_e[19:10]));
      end
    end
  end

  function automatic logic [W-1:0] model(input logic [15:0] sd,
                                         input logic sa,
                                         input logic [5:0] m);
    logic [15:0] l;
    logic [9:0] a0;
    logic [9:0] a1;
    l  = (sd == 16'd0) ? 16'hACE1 : sd;
    a0 = {m, 4'b0000};
    a1 = '0;
    for (int k = 0; k < N; k++) begin
      if (sa || l[0]) begin
        a0 = a0 + mem[k][9:0];
        a1 = a1 + mem[k][19:10];
      end
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    return {a1, a0};
  endfunction

  task automatic fill(input logic [9:0] r0, input logic [9:0] r1);
    for (int k = 0; k < N; k++) mem[k] = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer m (optionally with a seed), push expectation, check latency
  task automatic start(input logic [5:0] m, input logic [W-1:0] exp,
                       input logic sv, input logic [15:0] sd);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; plaintext = m; seed_valid = sv; seed = sd;
    tick();
    in_valid = 1'b0; seed_valid = 1'b0;
    sb.push_back(exp);
    lat = 1;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    chk("latency", lat, N + 2);
  endtask

  task automatic run(input logic [5:0] m, input logic [W-1:0] exp,
                     input logic sv, input logic [15:0] sd);
    start(m, exp, sv, sd);
    chk("pk_addr_hold", 32'(pk_addr), N - 1);
    tick();
    chk("ready_after_xfer", 32'(in_ready), 1);
  endtask

  initial begin
    tbl[0] = '{10'd1,    10'd0,    6'd5,  10'd110, 10'd0};
    tbl[1] = '{10'd0,    10'd0,    6'd63, 10'd1008, 10'd0};
    tbl[2] = '{10'd40,   10'd1000, 6'd0,  10'd176, 10'd304};
    tbl[3] = '{10'd1,    10'd2,    6'd1,  10'd46,  10'd60};
    tbl[4] = '{10'd1023, 10'd1023, 6'd63, 10'd978, 10'd994};

    rst = 1'b1; in_valid = 1'b0; plaintext = '0; seed_valid = 1'b0;
    seed = '0; sel_all = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pk_re", 32'(pk_re), 0);
    chk("rst_pk_addr", 32'(pk_addr), 0);
    chk("rst_ct", 32'(ciphertext), 0);

    for (int v = 0; v < 5; v++) begin
      fill(tbl[v].r0, tbl[v].r1);
      run(tbl[v].m, {tbl[v].e1, tbl[v].e0}, 1'b0, 16'd0);
    end

    // Backpressure: output held, new plaintext refused
    fill(10'd1, 10'd2);
    out_ready = 1'b0;
    start(6'd1, {10'd60, 10'd46}, 1'b0, 16'd0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; plaintext = 6'd9;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ct0", 32'(ciphertext[9:0]), 46);
      chk("bp_ct1", 32'(ciphertext[19:10]), 60);
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_released", 32'(out_valid), 0);
    repeat (N + 5) tick();
    chk("bp_no_accept", 32'(out_valid), 0);

    // Reset mid-operation at T+10
    fill(10'd1, 10'd0);
    in_valid = 1'b1; plaintext = 6'd7;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_pk_re", 32'(pk_re), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    tick();
    rst = 1'b0;
    run(6'd5, {10'd0, 10'd110}, 1'b0, 16'd0);

    // LFSR row selection
    sel_all = 1'b0;
    for (int k = 0; k < N; k++) mem[k] = W'($urandom);
    seed_valid = 1'b1; seed = 16'h0001;
    tick();
    seed_valid = 1'b0;
    run(6'd17, model(16'h0001, 1'b0, 6'd17), 1'b0, 16'd0);
    run(6'd42, model(16'h0000, 1'b0, 6'd42), 1'b1, 16'h0000);
    run(6'd42, model(16'hACE1, 1'b0, 6'd42), 1'b1, 16'hACE1);
    run(6'd3, model(16'hBEEF, 1'b0, 6'd3), 1'b1, 16'hBEEF);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
